// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter register and next-PC selection. Resolves
//               branch / JAL / JALR control transfers from the comparator
//               result and decode flags, raises a one-cycle wrong-path flush
//               after each taken transfer, and traps misaligned targets to
//               TRAP_VEC until the handler acknowledges.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               stall               - freeze request (RUN and FLUSH)
//               instr_valid         - instruction at pc is valid
//               is_branch/jal/jalr  - decoded control-transfer flags
//               comp                - branch comparison result (1 = taken)
//               imm, rs1_val        - immediate and rs1 operand
//               trap_ack            - trap handler acknowledge
//               pc, pc_plus4        - fetch PC and link value
//               flush, misaligned   - wrong-path kill, trap pending
//               trap_pc             - PC of the faulting transfer
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        instr_valid,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        comp,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        trap_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misaligned,
    output logic [31:0] trap_pc
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_flush;
    logic        r_misaligned;
    logic [31:0] r_trap_pc;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_flush_nxt;
    logic        w_misaligned_nxt;
    logic [31:0] w_trap_pc_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_target_bad;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jalr_sum = rs1_val + imm;

    // JALR wins over JAL/branch; JAL and branch share the pc-relative adder.
    // JALR clears bit 0, so its alignment check effectively looks at bit 1.
    assign w_target     = is_jalr ? {w_jalr_sum[31:1], 1'b0} : (r_pc + imm);
    assign w_taken      = instr_valid & (is_jalr | is_jal | (is_branch & comp));
    assign w_target_bad = (w_target[1:0] != 2'b00);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_flush_nxt      = r_flush;
        w_misaligned_nxt = r_misaligned;
        w_trap_pc_nxt    = r_trap_pc;

        case (r_state)
            ST_RUN: begin
                if (!stall && instr_valid) begin
                    if (!w_taken) begin
                        w_pc_nxt = w_pc_plus4;
                    end else if (w_target_bad) begin
                        w_pc_nxt         = TRAP_VEC;
                        w_trap_pc_nxt    = r_pc;
                        w_misaligned_nxt = 1'b1;
                        w_state_nxt      = ST_TRAP;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_flush_nxt = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Decode inputs are from the wrong path here and are ignored.
                if (!stall) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_TRAP: begin
                // pc already sits at TRAP_VEC; the release cycle fetches there.
                if (trap_ack) begin
                    w_misaligned_nxt = 1'b0;
                    w_state_nxt      = ST_RUN;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean RUN state.
                w_flush_nxt      = 1'b0;
                w_misaligned_nxt = 1'b0;
                w_state_nxt      = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_trap_pc    <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_flush      <= w_flush_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_trap_pc    <= w_trap_pc_nxt;
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign flush      = r_flush;
    assign misaligned = r_misaligned;
    assign trap_pc    = r_trap_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit. Directed scenarios followed
//               by randomized traffic, all compared against a behavioural
//               model of the program-counter rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VEC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        instr_valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        comp;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        trap_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misaligned;
    logic [31:0] trap_pc;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_mis;
    logic [31:0] m_tpc;

    pc_unit #(
        .RESET_PC (C_RESET_PC),
        .TRAP_VEC (C_TRAP_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .instr_valid (instr_valid),
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .comp        (comp),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .trap_ack    (trap_ack),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .flush       (flush),
        .misaligned  (misaligned),
        .trap_pc     (trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: one clock edge applied with the inputs currently driven.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        tk;
        if (reset) begin
            m_pc = C_RESET_PC; m_flush = 1'b0; m_mis = 1'b0; m_tpc = 32'h0;
        end else if (m_mis) begin
            if (trap_ack) m_mis = 1'b0;
        end else if (m_flush) begin
            if (!stall) m_flush = 1'b0;
        end else if (!stall && instr_valid) begin
            if (is_jalr) begin
                tk  = 1'b1;
                tgt = (rs1_val + imm) & 32'hFFFF_FFFE;
            end else begin
                tk  = is_jal || (is_branch && comp);
                tgt = m_pc + imm;
            end
            if (!tk) begin
                m_pc = m_pc + 32'd4;
            end else if ((tgt % 4) != 0) begin
                m_tpc = m_pc; m_pc = C_TRAP_VEC; m_mis = 1'b1;
            end else begin
                m_pc = tgt; m_flush = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("pc",         pc,                 m_pc);
        chk("pc_plus4",   pc_plus4,           m_pc + 32'd4);
        chk("flush",      {31'd0, flush},      {31'd0, m_flush});
        chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        chk("trap_pc",    trap_pc,            m_tpc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic br, input logic j, input logic jr,
                         input logic c, input logic [31:0] im, input logic [31:0] rs);
        instr_valid = v; is_branch = br; is_jal = j; is_jalr = jr;
        comp = c; imm = im; rs1_val = rs;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stall = 1'b0; trap_ack = 1'b0; reset = 1'b0;
    endtask

    // Jump to an aligned address with JAL, then let the flush cycle drain.
    task automatic goto_pc(input logic [31:0] addr);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, addr - m_pc, 32'h0);
        step();
        idle();
        step();
    endtask

    initial begin
        m_pc = 32'h0; m_flush = 1'b0; m_mis = 1'b0; m_tpc = 32'h0;
        idle();
        reset = 1'b1;
        step();
        step();
        chk("reset_pc", pc, C_RESET_PC);
        reset = 1'b0;

        // Sequential fetch
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step(); step();
        chk("seq_pc", pc, 32'hC);

        // Taken BEQ at 0x10 with imm=-8
        goto_pc(32'h10);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
        step();
        chk("beq_pc", pc, 32'h8);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        idle();
        step();
        chk("beq_flush_1cyc", {31'd0, flush}, 32'd0);

        // Not-taken BEQ at 0x10
        goto_pc(32'h10);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        step();
        chk("beq_nt_pc", pc, 32'h14);

        // JALR with bit 0 cleared: aligned
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1001);
        step();
        chk("jalr_clr0", pc, 32'h1000);
        idle(); step();

        // JALR misaligned at 0x40
        goto_pc(32'h40);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1002);
        step();
        chk("trap_pc_val", trap_pc, 32'h40);
        chk("trap_vec", pc, C_TRAP_VEC);
        idle();
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        step(); step();
        chk("trap_hold", {31'd0, misaligned}, 32'd1);
        idle();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("post_trap_fetch", pc, 32'h104);

        // Stalled JAL at 0x20
        goto_pc(32'h20);
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        step(); step();
        chk("stall_hold", pc, 32'h20);
        stall = 1'b0;
        step();
        chk("jal_after_stall", pc, 32'h60);
        stall = 1'b1;
        idle(); stall = 1'b1;
        step(); step();
        chk("flush_stalled", {31'd0, flush}, 32'd1);
        stall = 1'b0;
        step();

        // Priority: JAL over not-taken branch
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        step();
        chk("prio_jal", pc, 32'h80);
        idle(); step();
        // Invalid instruction with JAL flag
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        step();
        chk("invalid_hold", pc, 32'h80);
        // Misaligned not-taken branch
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 32'h0);
        step();
        chk("nt_misaligned", pc, 32'h84);

        // Reset in TRAP
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2, 32'h0);
        step();
        idle(); reset = 1'b1;
        step();
        chk("reset_in_trap", {31'd0, misaligned}, 32'd0);
        reset = 1'b0;

        // Wrap of pc+4 and of pc+imm
        goto_pc(32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("wrap_pc4", pc, 32'h0);
        goto_pc(32'hFFFF_FFF0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        step();
        chk("wrap_imm", pc, 32'h10);
        idle(); step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rimm;
            rimm = $urandom;
            if ($urandom_range(0, 1) == 0) rimm[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) rimm = {{20{rimm[11]}}, rimm[11:0]};
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom), rimm, $urandom);
            stall    = ($urandom_range(0, 3) == 0);
            trap_ack = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter register and next-PC selection stage, directly downstream of the branch comparator.
- Consumes the comparator's 1-bit `comp` result together with decoded control-transfer flags and the immediate and rs1 operands.
- Produces the fetch PC, the link value `pc + 4`, a one-cycle wrong-path flush, and a misaligned-target trap with acknowledge handshake.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- TRAP_VEC, 32'h00000100, PC loaded on a misaligned control-transfer target.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze request from the pipeline; holds all state in RUN and FLUSH.
- instr_valid  in  1  the instruction at pc is valid and its decode flags and operands are stable.
- is_branch  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- is_jal  in  1  JAL.
- is_jalr  in  1  JALR.
- comp  in  1  branch comparison result from the comparator; taken when 1.
- imm  in  32  sign-extended immediate.
- rs1_val  in  32  rs1 operand, used by JALR only.
- trap_ack  in  1  trap handler acknowledge.
- pc  out  32  current fetch PC (registered).
- pc_plus4  out  32  pc + 4, combinational, used as the link value.
- flush  out  1  kill the wrong-path instruction (registered).
- misaligned  out  1  instruction-address-misaligned trap pending (registered).
- trap_pc  out  32  PC of the faulting control-transfer instruction (registered).

Behaviour:
- Reset (checked at the clock edge, overrides every other input and any state): pc=RESET_PC, state=RUN, flush=0, misaligned=0, trap_pc=0.
- Arithmetic is 32-bit modulo 2^32; carries are discarded.
  - Branch/JAL target = pc + imm.
  - JALR target = (rs1_val + imm) with bit 0 forced to 0.
- Decode-flag priority when more than one flag is set: is_jalr > is_jal > is_branch.
- taken = instr_valid & (is_jalr | is_jal | (is_branch & comp)).
- The misalignment check applies only to taken transfers: bad when target[1:0] != 2'b00.
  - Not-taken branches never trap.
  - JALR checks bit 1 only, since bit 0 is cleared.
- States: RUN, FLUSH, TRAP (2-bit encoding, free choice).
- RUN:
  - stall=1: all state holds; the instruction is not consumed.
  - stall=0, instr_valid=0: pc holds (fetch bubble).
  - stall=0, valid, not taken: pc <= pc+4, stay in RUN.
  - stall=0, taken, aligned target: pc <= target, flush <= 1, go to FLUSH.
  - stall=0, taken, misaligned target: pc <= TRAP_VEC, trap_pc <= pc, misaligned <= 1, go to TRAP.
- FLUSH (entered after every taken transfer; lasts at least 1 cycle):
  - flush=1 throughout; instr_valid and the decode inputs are ignored; pc holds.
  - stall=0: flush <= 0, go to RUN.
  - stall=1: stay in FLUSH with flush held at 1.
- TRAP:
  - misaligned=1 and pc=TRAP_VEC hold; instr_valid and stall are ignored.
  - trap_ack=1: misaligned <= 0, go to RUN; the next cycle fetches at TRAP_VEC.
  - trap_ack asserted outside TRAP is ignored.
- Latency:
  - Redirect visible on pc one cycle after the resolving edge.
  - flush asserted in the same cycle the new pc appears.
- Boundaries:
  - pc=32'hFFFFFFFC not taken -> pc wraps to 0.
  - pc + imm wraps modulo 2^32 without error.
  - Reset during FLUSH or TRAP returns to RUN at RESET_PC with flush and misaligned cleared.
- pc_plus4 always reflects the current registered pc, including during stall, FLUSH and TRAP.

Test Plan:
- Reset then sequential fetch: reset 2 cycles, instr_valid=1 with no flags for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0; pc_plus4 always pc+4.
- Taken BEQ: pc=0x10, is_branch=1, comp=1, imm=-8 -> next pc=0x08, flush=1 for exactly 1 cycle, then RUN. Same with comp=0 -> pc=0x14, no flush.
- JALR alignment: rs1_val=0x1001, imm=0 -> pc=0x1000, no trap. rs1_val=0x1002, imm=0 at pc=0x40 -> pc=TRAP_VEC=0x100, trap_pc=0x40, misaligned=1 until trap_ack; then RUN, fetch continues at 0x100.
- Stall interaction: stall=1 during a taken JAL (pc=0x20, imm=0x40) -> pc holds at 0x20 while stalled; after release -> pc=0x60 with flush. stall=1 inside FLUSH -> flush stays 1 until release.
- Priority and gating: is_jal=1 and is_branch=1 with comp=0 -> JAL taken. instr_valid=0 with is_jal=1 -> pc holds, no flush. Misaligned not-taken branch (imm=2, comp=0) -> pc+4, no trap.
- Reset mid-operation and wrap: assert reset while in TRAP -> pc=RESET_PC, misaligned=0 next cycle. pc=0xFFFFFFFC not taken -> pc=0x00000000.
